// File: rtl/vec_act_seq_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// vec_act_seq_if
// Handshake bundle for the sequential vector activation unit.
//
// Input channel : in_valid / in_ready, in_vec, mode (mode travels with in_vec)
// Output channel: out_valid / out_ready, out_vec
//
// master : the side that produces vectors and consumes results
// slave  : the activation unit
// ----------------------------------------------------------------------------
interface vec_act_seq_if #(
  parameter int ELEM_W   = 32,
  parameter int VEC_SIZE = 4
);

  logic                       in_valid;
  logic                       in_ready;
  logic [VEC_SIZE*ELEM_W-1:0] in_vec;
  logic [1:0]                 mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [VEC_SIZE*ELEM_W-1:0] out_vec;

  modport master (
    output in_valid,
    output in_vec,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_vec
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_vec
  );

endinterface

// File: rtl/vec_act_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// vec_act_seq
// Sequential multi-mode activation over one float vector per transaction.
// A vector and its mode are latched on input acceptance, LANES elements are
// transformed per cycle into a result register, and the finished vector is
// offered on the output channel until it is taken.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high; aborts any transaction in flight
//   bus    : vec_act_seq_if.slave (input and output valid/ready channels)
//   busy   : high while elements are being processed
//
// Modes: 00 PASS, 01 RELU, 10 LEAKY (slope 2^-LEAK_SHIFT), 11 CLAMP to [0,1].
// NaN inputs pass through unchanged in every mode.
// VEC_SIZE must be a multiple of LANES.
// ----------------------------------------------------------------------------
module vec_act_seq #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int VEC_SIZE   = 4,
  parameter int LANES      = 1,
  parameter int LEAK_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  vec_act_seq_if.slave bus,
  output logic         busy
);

  localparam int W     = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int VW    = VEC_SIZE * W;
  localparam int N     = VEC_SIZE / LANES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [EXP_WIDTH-1:0] BIAS     = {1'b0, {(EXP_WIDTH-1){1'b1}}};
  localparam logic [EXP_WIDTH-1:0] LEAK     = EXP_WIDTH'(LEAK_SHIFT);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_CLAMP = 2'b11
  } mode_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VW-1:0]    vec_q, vec_d;
  mode_e            mode_q, mode_d;
  logic [VW-1:0]    res_q, res_d;

  // Per-element activation. Leaky ReLU scales by 2^-LEAK_SHIFT through the
  // exponent only; anything that would become subnormal flushes to -0.
  function automatic logic [W-1:0] act_elem(input logic [W-1:0] x, input mode_e md);
    logic                  s;
    logic [EXP_WIDTH-1:0]  e;
    logic [MANT_WIDTH-1:0] m;
    logic [W-1:0]          y;
    s = x[W-1];
    e = x[W-2 -: EXP_WIDTH];
    m = x[MANT_WIDTH-1:0];
    y = x;
    if (!((&e) && (|m))) begin
      case (md)
        MODE_RELU: begin
          if (s) y = '0;
        end
        MODE_LEAKY: begin
          // Exponent all-ones here can only be -inf, which is kept.
          if (s && !(&e)) begin
            if (e > LEAK) y = {1'b1, e - LEAK, m};
            else          y = {1'b1, {(W-1){1'b0}}};
          end
        end
        MODE_CLAMP: begin
          if (s)              y = '0;
          else if (e >= BIAS) y = {1'b0, BIAS, {MANT_WIDTH{1'b0}}};
        end
        default: y = x;
      endcase
    end
    return y;
  endfunction

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)       state_d = ST_BUSY;
      ST_BUSY: if (idx_q == IDX_LAST)  state_d = ST_DONE;
      ST_DONE: if (bus.out_ready)      state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      ST_IDLE: bus.in_ready  = 1'b1;
      ST_BUSY: busy          = 1'b1;
      ST_DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_vec = res_q;

  // Datapath next-state: latch on acceptance, transform one chunk per BUSY
  // cycle. Result slots not in the current chunk hold their value.
  always_comb begin
    idx_d  = idx_q;
    vec_d  = vec_q;
    mode_d = mode_q;
    res_d  = res_q;
    if (state_q == ST_IDLE && bus.in_valid) begin
      vec_d  = bus.in_vec;
      mode_d = mode_e'(bus.mode);
      idx_d  = '0;
    end else if (state_q == ST_BUSY) begin
      for (int l = 0; l < LANES; l++) begin
        res_d[(int'(idx_q)*LANES + l)*W +: W] =
          act_elem(vec_q[(int'(idx_q)*LANES + l)*W +: W], mode_q);
      end
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Datapath registers
  // NOTE: the data registers are reset as well, because res_q drives out_vec
  // directly and must read as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      vec_q  <= '0;
      mode_q <= MODE_PASS;
      res_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      vec_q  <= vec_d;
      mode_q <= mode_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_vec_act_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_vec_act_seq
// Two instances share one stimulus driver: u_dut_l1 (LANES=1, N=4) and
// u_dut_l2 (LANES=2, N=2); sel picks which one is active. Expected vectors are
// queued when a vector is accepted and compared when a result is taken.
// ----------------------------------------------------------------------------
module tb_vec_act_seq;

  localparam logic [1:0] M_PASS  = 2'b00;
  localparam logic [1:0] M_RELU  = 2'b01;
  localparam logic [1:0] M_LEAKY = 2'b10;
  localparam logic [1:0] M_CLAMP = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;
  logic         drv_valid;
  logic [127:0] drv_vec;
  logic [1:0]   drv_mode;
  logic         drv_ready;
  logic         rnd_en;
  logic         rnd_ready;
  logic         eff_ready;
  logic         busy_a, busy_b;
  logic         obs_in_ready, obs_out_valid, obs_busy;
  logic [127:0] obs_out_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sent   = 0;
  int n_rcv    = 0;
  int waits, lat, nb;
  logic [127:0] exp_q[$];

  vec_act_seq_if #(.ELEM_W(32), .VEC_SIZE(4)) if_a ();
  vec_act_seq_if #(.ELEM_W(32), .VEC_SIZE(4)) if_b ();

  assign eff_ready      = rnd_en ? rnd_ready : drv_ready;
  assign if_a.in_valid  = drv_valid & ~sel;
  assign if_b.in_valid  = drv_valid &  sel;
  assign if_a.in_vec    = drv_vec;
  assign if_b.in_vec    = drv_vec;
  assign if_a.mode      = drv_mode;
  assign if_b.mode      = drv_mode;
  assign if_a.out_ready = eff_ready & ~sel;
  assign if_b.out_ready = eff_ready &  sel;

  assign obs_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
  assign obs_out_valid = sel ? if_b.out_valid : if_a.out_valid;
  assign obs_out_vec   = sel ? if_b.out_vec   : if_a.out_vec;
  assign obs_busy      = sel ? busy_b         : busy_a;

  vec_act_seq #(
    .EXP_WIDTH(8), .MANT_WIDTH(23), .VEC_SIZE(4), .LANES(1), .LEAK_SHIFT(2)
  ) u_dut_l1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a),
    .busy  (busy_a)
  );

  vec_act_seq #(
    .EXP_WIDTH(8), .MANT_WIDTH(23), .VEC_SIZE(4), .LANES(2), .LEAK_SHIFT(2)
  ) u_dut_l2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b),
    .busy  (busy_b)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one fp32 element, LEAK_SHIFT = 2.
  function automatic logic [31:0] ref_elem(input logic [31:0] x, input logic [1:0] md);
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = x[31];
    e = x[30:23];
    m = x[22:0];
    if (e == 8'hFF && m != 23'h0) return x;
    case (md)
      M_PASS: return x;
      M_RELU: return s ? 32'h0 : x;
      M_LEAKY: begin
        if (!s || x == 32'hFF80_0000) return x;
        if (e > 8'd2) return {1'b1, e - 8'd2, m};
        return 32'h8000_0000;
      end
      default: begin
        if (s) return 32'h0;
        if (e >= 8'd127) return 32'h3F80_0000;
        return x;
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_elem();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = {r[31], 8'hFF, r[22:0] | 23'h1};
      1: r = {r[31], 8'hFF, 23'h0};
      2: r = {r[31], 31'h0};
      3: r = {r[31], 8'($urandom_range(0, 3)), r[22:0]};
      4: r = {r[31], 8'($urandom_range(125, 129)), r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  // Random output back-pressure, applied only during the random phase.
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: a result is taken at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!reset && obs_out_valid && eff_ready) begin
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("sb_vec", obs_out_vec, exp_q.pop_front());
        n_rcv++;
      end
    end
  end

  // Offer a vector; returns #1 after the acceptance edge. waits counts the
  // negedges observed before acceptance, including the accepting one.
  task automatic send(input logic [127:0] v, input logic [1:0] md,
                      input logic [127:0] exp, output int w);
    bit ok;
    ok        = 1'b0;
    w         = 0;
    drv_vec   = v;
    drv_mode  = md;
    drv_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      w++;
      if (obs_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", ok, 1);
    else begin
      exp_q.push_back(exp);
      n_sent++;
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_vec   = {$urandom, $urandom, $urandom, $urandom};
    drv_mode  = 2'($urandom_range(0, 3));
  endtask

  // Called right after acceptance: lat counts edges from acceptance to out_valid.
  task automatic wait_done(output int l, output int nbusy);
    bit ok;
    ok    = 1'b0;
    l     = 1;
    nbusy = 0;
    for (int i = 0; i < 64; i++) begin
      if (obs_out_valid) begin
        ok = 1'b1;
        break;
      end
      if (obs_busy) nbusy++;
      @(posedge clk);
      #1;
      l++;
    end
    if (!ok) check("done_timeout", ok, 1);
  endtask

  task automatic drain();
    rnd_en    = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_random(input int count, input logic which);
    logic [127:0] v, e;
    logic [1:0]   md;
    int           w;
    sel    = which;
    rnd_en = 1'b1;
    for (int k = 0; k < count; k++) begin
      md = 2'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) begin
        v[j*32 +: 32] = rand_elem();
        e[j*32 +: 32] = ref_elem(v[j*32 +: 32], md);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(v, md, e, w);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_rcv=%0d n_sent=%0d", n_rcv, n_sent);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_vec   = '0;
    drv_mode  = M_PASS;
    drv_ready = 1'b1;
    rnd_en    = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("por_in_ready_a",  if_a.in_ready,  1);
    check("por_out_valid_a", if_a.out_valid, 0);
    check("por_busy_a",      busy_a,         0);
    check("por_out_vec_a",   if_a.out_vec,   0);
    check("por_in_ready_b",  if_b.in_ready,  1);
    check("por_busy_b",      busy_b,         0);

    // Reset for 2 cycles in the middle of BUSY discards the transaction
    @(posedge clk);
    #1;
    send({32'h4040_0000, 32'h8000_0000, 32'hC000_0000, 32'h3F80_0000}, M_RELU,
         {32'h4040_0000, 32'h0, 32'h0, 32'h3F80_0000}, waits);
    @(posedge clk);
    #1;
    check("mid_busy", obs_busy, 1);
    reset = 1'b1;
    exp_q.delete();
    n_sent = n_rcv;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  obs_in_ready,  1);
    check("rst_out_valid", obs_out_valid, 0);
    check("rst_busy",      obs_busy,      0);
    check("rst_out_vec",   obs_out_vec,   0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_out", obs_out_valid, 0);
    end

    // RELU, LANES=1: latency and busy window
    @(posedge clk);
    #1;
    send({32'h4040_0000, 32'h8000_0000, 32'hC000_0000, 32'h3F80_0000}, M_RELU,
         {32'h4040_0000, 32'h0, 32'h0, 32'h3F80_0000}, waits);
    wait_done(lat, nb);
    check("relu_latency", lat, 5);
    check("relu_busy_cycles", nb, 4);
    @(posedge clk);
    #1;
    check("relu_in_ready_after", obs_in_ready, 1);
    check("relu_out_valid_after", obs_out_valid, 0);

    // LEAKY, LANES=1
    send({32'h7FC0_0001, 32'hFF80_0000, 32'h8080_0000, 32'hC000_0000}, M_LEAKY,
         {32'h7FC0_0001, 32'hFF80_0000, 32'h8000_0000, 32'hBF00_0000}, waits);
    wait_done(lat, nb);
    check("leaky_latency", lat, 5);
    drain();

    // CLAMP, LANES=2
    sel = 1'b1;
    send({32'h7F80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h4040_0000}, M_CLAMP,
         {32'h3F80_0000, 32'h0, 32'h3F00_0000, 32'h3F80_0000}, waits);
    wait_done(lat, nb);
    check("clamp_latency", lat, 3);
    check("clamp_busy_cycles", nb, 2);
    drain();

    // Back-pressure in DONE with a new vector waiting on the input
    sel       = 1'b0;
    drv_ready = 1'b0;
    send({32'hBF80_0000, 32'h3F00_0000, 32'hC040_0000, 32'h1234_5678}, M_PASS,
         {32'hBF80_0000, 32'h3F00_0000, 32'hC040_0000, 32'h1234_5678}, waits);
    wait_done(lat, nb);
    drv_vec   = {32'hC000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h4120_0000};
    drv_mode  = M_LEAKY;
    drv_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_vec", obs_out_vec,
            {32'hBF80_0000, 32'h3F00_0000, 32'hC040_0000, 32'h1234_5678});
      check("bp_in_ready", obs_in_ready, 0);
    end
    @(posedge clk);
    #1 drv_ready = 1'b1;
    send({32'hC000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h4120_0000}, M_RELU,
         {32'h0, 32'h3F80_0000, 32'h0, 32'h4120_0000}, waits);
    check("bp_accept_delay", waits, 2);
    wait_done(lat, nb);
    check("bp_latency", lat, 5);
    drain();

    // Random traffic with input and output stalls on both configurations
    run_random(600, 1'b0);
    drain();
    run_random(400, 1'b1);
    drain();

    check("sb_count", n_rcv, n_sent);
    check("sb_total", n_sent, 1005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
